// File: rtl/sid_envelope.sv
// Per-voice SID ADSR envelope: rate counter, exponential decay divider and ATTACK/DECAY_SUSTAIN/RELEASE FSM.
// Build option SID_ENV_ADSR_BUG_EN: exact-match rate tick, reproducing the hardware ADSR delay bug.
module sid_envelope #(
  parameter int RATE_BITS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phi2_en,
  input  logic       gate,
  input  logic [3:0] attack,
  input  logic [3:0] decay,
  input  logic [3:0] sustain,
  input  logic [3:0] release_rate,
  output logic [7:0] env_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_RELEASE       = 2'd0,
    ST_ATTACK        = 2'd1,
    ST_DECAY_SUSTAIN = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [RATE_BITS-1:0] rate_cnt_reg, rate_cnt_next;
  logic [4:0]           exp_cnt_reg, exp_cnt_next;
  logic [7:0]           env_reg, env_next;
  logic                 gate_prev_reg;

  logic [3:0]           rate_idx;
  logic [RATE_BITS-1:0] period_m1;
  logic [4:0]           exp_m1;
  logic                 rate_tick, exp_tick;
  logic                 gate_rise, gate_fall;
  logic [7:0]           sustain_level;

  // Rate period minus one, so the tick compare needs no subtractor.
  function automatic logic [RATE_BITS-1:0] rate_period_m1(input logic [3:0] idx);
    case (idx)
      4'd0:    rate_period_m1 = RATE_BITS'(8);
      4'd1:    rate_period_m1 = RATE_BITS'(31);
      4'd2:    rate_period_m1 = RATE_BITS'(62);
      4'd3:    rate_period_m1 = RATE_BITS'(94);
      4'd4:    rate_period_m1 = RATE_BITS'(148);
      4'd5:    rate_period_m1 = RATE_BITS'(219);
      4'd6:    rate_period_m1 = RATE_BITS'(266);
      4'd7:    rate_period_m1 = RATE_BITS'(312);
      4'd8:    rate_period_m1 = RATE_BITS'(391);
      4'd9:    rate_period_m1 = RATE_BITS'(976);
      4'd10:   rate_period_m1 = RATE_BITS'(1953);
      4'd11:   rate_period_m1 = RATE_BITS'(3125);
      4'd12:   rate_period_m1 = RATE_BITS'(3906);
      4'd13:   rate_period_m1 = RATE_BITS'(11719);
      4'd14:   rate_period_m1 = RATE_BITS'(19531);
      default: rate_period_m1 = RATE_BITS'(31250);
    endcase
  endfunction

  // Piecewise approximation of an exponential curve, chosen by the current level.
  function automatic logic [4:0] exp_period_m1(input logic [7:0] level);
    if (level >= 8'h5E)      exp_period_m1 = 5'd0;
    else if (level >= 8'h37) exp_period_m1 = 5'd1;
    else if (level >= 8'h1B) exp_period_m1 = 5'd3;
    else if (level >= 8'h0F) exp_period_m1 = 5'd7;
    else if (level >= 8'h07) exp_period_m1 = 5'd15;
    else if (level >= 8'h01) exp_period_m1 = 5'd29;
    else                     exp_period_m1 = 5'd0;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RELEASE;
      rate_cnt_reg  <= '0;
      exp_cnt_reg   <= '0;
      env_reg       <= '0;
      gate_prev_reg <= 1'b0;
    end else if (phi2_en) begin
      state_reg     <= state_next;
      rate_cnt_reg  <= rate_cnt_next;
      exp_cnt_reg   <= exp_cnt_next;
      env_reg       <= env_next;
      gate_prev_reg <= gate;
    end
  end

  // Tick generation; rate registers are read combinationally on the strobe they are written.
  always_comb begin
    rate_idx = release_rate;
    case (state_reg)
      ST_ATTACK:        rate_idx = attack;
      ST_DECAY_SUSTAIN: rate_idx = decay;
      default:          rate_idx = release_rate;
    endcase
    period_m1 = rate_period_m1(rate_idx);
`ifdef SID_ENV_ADSR_BUG_EN
    rate_tick = (rate_cnt_reg == period_m1);
`else
    rate_tick = (rate_cnt_reg >= period_m1);
`endif
    rate_cnt_next = rate_tick ? '0 : rate_cnt_reg + RATE_BITS'(1);
    exp_m1        = exp_period_m1(env_reg);
    exp_tick      = rate_tick && (exp_cnt_reg == exp_m1);
    gate_rise     = gate & ~gate_prev_reg;
    gate_fall     = ~gate & gate_prev_reg;
    sustain_level = {sustain, sustain};
  end

  // Next-state and envelope update; a gate edge swallows a coincident tick.
  always_comb begin
    state_next   = state_reg;
    env_next     = env_reg;
    exp_cnt_next = exp_cnt_reg;
    if (gate_rise) begin
      state_next   = ST_ATTACK;
      exp_cnt_next = '0;
    end else if (gate_fall) begin
      state_next = ST_RELEASE;
    end else if (rate_tick) begin
      case (state_reg)
        ST_ATTACK: begin
          if (env_reg != 8'hFF) env_next = env_reg + 8'd1;
          if (env_reg >= 8'hFE) state_next = ST_DECAY_SUSTAIN;
        end
        ST_DECAY_SUSTAIN: begin
          exp_cnt_next = exp_tick ? 5'd0 : exp_cnt_reg + 5'd1;
          if (exp_tick && env_reg != sustain_level && env_reg != 8'h00)
            env_next = env_reg - 8'd1;
        end
        default: begin
          exp_cnt_next = exp_tick ? 5'd0 : exp_cnt_reg + 5'd1;
          if (exp_tick && env_reg != 8'h00)
            env_next = env_reg - 8'd1;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    env_o   = env_reg;
    state_o = state_reg;
  end

endmodule
